x_in_serializer: RTL
====================

// Module: x_in_serializer
// PURPOSE
//   Upstream feeder for the 2-bit Moore sequence FSM: accepts parallel words via a
//   valid/ready handshake and shifts them out one bit at a time on x_in, which
//   drives the FSM's x_in. Adds programmable bit period, bit order, idle level and
//   inter-word gap, plus a done pulse and a sent-word counter.
// PARAMETERS
//   WIDTH       8     bits per word (>=1)
//   BIT_DIV     1     clocks each bit is held on x_in (>=1)
//   MSB_FIRST   1     1: data_in[WIDTH-1] sent first; 0: data_in[0] first
//   IDLE_LEVEL  1'b1  x_in level whenever no bit is being sent (1 parks FSM in S0)
//   GAP         0     idle clocks forced between words (>=0)
//   CNT_W       16    width of word_count
// PORTS
//   clock       in   1        single clock, rising edge
//   reset       in   1        asynchronous, active-low reset
//   data_in     in   WIDTH    word to send; sampled only on accept
//   load_valid  in   1        producer has a word on data_in
//   load_ready  out  1        serializer can accept (combinational from state/counters)
//   x_in        out  1        serial bit to downstream FSM (registered)
//   x_valid     out  1        x_in carries a data bit (registered)
//   busy        out  1        state != IDLE
//   word_done   out  1        one-clock pulse: last bit period of a word just ended
//   word_count  out  CNT_W    completed words, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   Reset (reset==0, async): state IDLE, x_in=IDLE_LEVEL, x_valid=0, word_done=0,
//     word_count=0, shift reg/counters 0; load_ready=1 immediately.
//   States: IDLE, SHIFT, GAP.
//   Accept = load_valid & load_ready at a rising edge; data_in captured, bit_cnt=WIDTH-1,
//     div_cnt=BIT_DIV-1, state->SHIFT. First bit on x_in, x_valid=1 in the next cycle
//     (latency 1 clock). data_in changes after accept have no effect.
//   IDLE: load_ready=1, x_in=IDLE_LEVEL, x_valid=0.
//   SHIFT: each bit held exactly BIT_DIV clocks; div_cnt decrements, at 0 advance to
//     next bit in MSB_FIRST order. At end of last bit period (bit_cnt==0, div_cnt==0):
//     word_done=1 and word_count+1 in the following cycle; next state GAP if GAP>0, else IDLE.
//   Back-to-back: when GAP==0, load_ready=1 also in the final clock of the last bit
//     period; an accept there goes straight to SHIFT with the new word's first bit in
//     the next cycle (no idle cycle, x_valid stays 1).
//   GAP: x_in=IDLE_LEVEL, x_valid=0, load_ready=0 for exactly GAP clocks, then IDLE.
//   load_valid while load_ready=0: ignored, nothing captured; producer must hold.
//   Reset mid-word: word discarded, no word_done, word_count -> 0, outputs to reset values.
//   word_count increments only on word_done; wrap is silent.
// TESTING
//   WIDTH=4,BIT_DIV=1,MSB_FIRST=1: accept 4'b0110 -> x_in 0,1,1,0 with x_valid=1 in
//     cycles 1-4 after accept; word_done=1 in cycle 5; word_count=1; x_in=1 after.
//   GAP=0, words 4'b1010 then 4'b0101 held valid -> 8 contiguous valid bits
//     1,0,1,0,0,1,0,1; load_ready high only in cycle 4; word_count=2.
//   BIT_DIV=3, 4'b1001 -> each bit held 3 clocks, 12 valid cycles, one word_done.
//   MSB_FIRST=0, GAP=2, 4'b0011 -> x_in 1,1,0,0; then 2 clocks load_ready=0,
//     x_in=IDLE_LEVEL; load_valid held during gap accepted on first IDLE edge.
//   Reset asserted after 2 bits of 4'b1100 -> x_in=1, x_valid=0, busy=0, load_ready=1
//     at once (no clock), no word_done, word_count=0.
//   CNT_W=2: send 4 words -> word_count 1,2,3,0.

Source files
------------

// File: rtl/x_in_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : x_in_serializer
//  Purpose  : Parallel-to-serial feeder driving the x_in input of the Moore FSM.
//  Revision : 1.0  initial release
// ============================================================================
module x_in_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   BIT_DIV    = 1,
   parameter int   MSB_FIRST  = 1,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter int   GAP        = 0,
   parameter int   CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             x_in,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done,
   output logic [CNT_W-1:0] word_count
);

   localparam int BW = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int GW = (GAP     > 1) ? $clog2(GAP)     : 1;

   localparam logic [BW-1:0] c_bit_max = BW'(WIDTH - 1);
   localparam logic [DW-1:0] c_div_max = DW'(BIT_DIV - 1);
   localparam logic [GW-1:0] c_gap_max = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_bit_cnt;
   logic [DW-1:0]    r_div_cnt;
   logic [GW-1:0]    r_gap_cnt;

   logic             w_last;
   logic             w_accept;
   logic             w_first_bit;
   logic             w_adv_bit;
   logic [WIDTH-1:0] w_load_shift;
   logic [WIDTH-1:0] w_adv_shift;

   // Final clock of the final bit period of the current word.
   assign w_last     = (r_state == ST_SHIFT) && (r_bit_cnt == '0) && (r_div_cnt == '0);
   assign load_ready = (r_state == ST_IDLE) || (w_last && (GAP == 0));
   assign w_accept   = load_valid && load_ready;
   assign busy       = (r_state != ST_IDLE);

   // x_in is registered, so the shifter holds only the bits not yet presented.
   always_comb begin
      w_first_bit  = data_in[0];
      w_load_shift = data_in >> 1;
      w_adv_bit    = r_shift[0];
      w_adv_shift  = r_shift >> 1;
      if (MSB_FIRST != 0) begin
         w_first_bit  = data_in[WIDTH-1];
         w_load_shift = data_in << 1;
         w_adv_bit    = r_shift[WIDTH-1];
         w_adv_shift  = r_shift << 1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_div_cnt  <= '0;
         r_gap_cnt  <= '0;
         x_in       <= IDLE_LEVEL;
         x_valid    <= 1'b0;
         word_done  <= 1'b0;
         word_count <= '0;
      end else begin
         word_done <= w_last;
         if (w_last) begin
            word_count <= word_count + CNT_W'(1);
         end
         if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_shift   <= w_load_shift;
            r_bit_cnt <= c_bit_max;
            r_div_cnt <= c_div_max;
            x_in      <= w_first_bit;
            x_valid   <= 1'b1;
         end else begin
            case (r_state)
               ST_SHIFT: begin
                  if (r_div_cnt != '0) begin
                     r_div_cnt <= r_div_cnt - DW'(1);
                  end else if (r_bit_cnt != '0) begin
                     r_bit_cnt <= r_bit_cnt - BW'(1);
                     r_div_cnt <= c_div_max;
                     r_shift   <= w_adv_shift;
                     x_in      <= w_adv_bit;
                  end else begin
                     x_in    <= IDLE_LEVEL;
                     x_valid <= 1'b0;
                     if (GAP > 0) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= c_gap_max;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               ST_GAP: begin
                  if (r_gap_cnt == '0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - GW'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
